// File: rtl/rgb_fade_seq.sv
// Colour-wheel fade sequencer: steps one RGB duty word per PERIODS_PER_STEP PWM periods,
// walking Red->Yellow->Green->Cyan->Blue->Magenta->Red with saturating arithmetic.
module rgb_fade_seq #(
  parameter int W                = 8,
  parameter int STEP             = 1,
  parameter int PERIODS_PER_STEP = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         period_start,
  output logic [W-1:0] r_duty,
  output logic [W-1:0] g_duty,
  output logic [W-1:0] b_duty,
  output logic         duty_upd,
  output logic [2:0]   phase
);

  localparam logic [W-1:0] MAX = '1;
  localparam int CNT_W = (PERIODS_PER_STEP > 1) ? $clog2(PERIODS_PER_STEP) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIODS_PER_STEP - 1);
  localparam logic [W:0] STEP_X = (W+1)'(STEP);

  // Handshake: period_start is a strobe with no back-pressure; it is consumed
  // only when en=1 and rst=0, and duty_upd strobes the cycle new duties appear.
  typedef enum logic [2:0] {
    RISE_G = 3'd0,
    FALL_R = 3'd1,
    RISE_B = 3'd2,
    FALL_G = 3'd3,
    RISE_R = 3'd4,
    FALL_B = 3'd5
  } phase_t;

  phase_t         state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]   r_d, g_d, b_d;
  logic           upd_d;

  logic           accept, step, rising;
  logic [W-1:0]   cur, stepped, endpoint;
  logic [W:0]     sum, diff;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RISE_G;
      cnt_q    <= '0;
      r_duty   <= MAX;
      g_duty   <= '0;
      b_duty   <= '0;
      duty_upd <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      r_duty   <= r_d;
      g_duty   <= g_d;
      b_duty   <= b_d;
      duty_upd <= upd_d;
    end
  end

  always_comb begin
    accept   = en && period_start;
    step     = accept && (cnt_q == CNT_LAST);
    rising   = (state_q == RISE_G) || (state_q == RISE_B) || (state_q == RISE_R);
    endpoint = rising ? MAX : '0;

    case (state_q)
      RISE_G, FALL_G: cur = g_duty;
      FALL_R, RISE_R: cur = r_duty;
      default:        cur = b_duty;
    endcase

    // One spare bit catches overflow past MAX and borrow below zero.
    sum  = {1'b0, cur} + STEP_X;
    diff = {1'b0, cur} - STEP_X;
    if (rising) stepped = (sum > {1'b0, MAX}) ? MAX : sum[W-1:0];
    else        stepped = diff[W] ? '0 : diff[W-1:0];

    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_duty;
    g_d     = g_duty;
    b_d     = b_duty;
    upd_d   = 1'b0;

    if (accept) cnt_d = step ? '0 : cnt_q + CNT_W'(1);

    if (step) begin
      upd_d = 1'b1;
      case (state_q)
        RISE_G, FALL_G: g_d = stepped;
        FALL_R, RISE_R: r_d = stepped;
        default:        b_d = stepped;
      endcase
      if (stepped == endpoint) begin
        case (state_q)
          RISE_G:  state_d = FALL_R;
          FALL_R:  state_d = RISE_B;
          RISE_B:  state_d = FALL_G;
          FALL_G:  state_d = RISE_R;
          RISE_R:  state_d = FALL_B;
          default: state_d = RISE_G;
        endcase
      end
    end
  end

  assign phase = state_q;

endmodule

// File: tb/tb_rgb_fade_seq.sv
// Table-driven bench for rgb_fade_seq: three parameterisations share the clock,
// expected outputs are queued when each vector is driven and popped one edge later.
module tb_rgb_fade_seq;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, en = 1'b1, ps8 = 1'b0, ps4a = 1'b0, ps4b = 1'b0;

  logic [7:0] r8, g8, b8;
  logic       upd8;
  logic [2:0] ph8;
  logic [3:0] r4a, g4a, b4a, r4b, g4b, b4b;
  logic       upd4a, upd4b;
  logic [2:0] ph4a, ph4b;

  rgb_fade_seq #(.W(8), .STEP(1), .PERIODS_PER_STEP(4)) dut8 (
    .clk(clk), .rst(rst), .en(en), .period_start(ps8),
    .r_duty(r8), .g_duty(g8), .b_duty(b8), .duty_upd(upd8), .phase(ph8));

  rgb_fade_seq #(.W(4), .STEP(4), .PERIODS_PER_STEP(1)) dut4a (
    .clk(clk), .rst(rst), .en(en), .period_start(ps4a),
    .r_duty(r4a), .g_duty(g4a), .b_duty(b4a), .duty_upd(upd4a), .phase(ph4a));

  rgb_fade_seq #(.W(4), .STEP(5), .PERIODS_PER_STEP(1)) dut4b (
    .clk(clk), .rst(rst), .en(en), .period_start(ps4b),
    .r_duty(r4b), .g_duty(g4b), .b_duty(b4b), .duty_upd(upd4b), .phase(ph4b));

  typedef struct {
    int          sel;
    logic        rst;
    logic        en;
    logic        ps;
    logic [27:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [27:0] exp_q[$];
  int          n_pass = 0;
  int          n_checks = 0;

  // reference model state for the W=4, STEP=5 instance
  int m_r = 15, m_g = 0, m_b = 0, m_ph = 0;

  function automatic logic [27:0] pk(int r, int g, int b, int ph, logic upd);
    return {8'(r), 8'(g), 8'(b), 3'(ph), upd};
  endfunction

  function automatic void add(int sel, logic rst_v, logic en_v, logic ps_v,
                              int r, int g, int b, int ph, logic upd);
    vec_t v;
    v.sel = sel; v.rst = rst_v; v.en = en_v; v.ps = ps_v;
    v.exp = pk(r, g, b, ph, upd);
    vecs.push_back(v);
  endfunction

  function automatic int up(int v);
    return (v + 5 > 15) ? 15 : v + 5;
  endfunction

  function automatic int dn(int v);
    return (v - 5 < 0) ? 0 : v - 5;
  endfunction

  function automatic void model_step();
    case (m_ph)
      0: begin m_g = up(m_g); if (m_g == 15) m_ph = 1; end
      1: begin m_r = dn(m_r); if (m_r == 0)  m_ph = 2; end
      2: begin m_b = up(m_b); if (m_b == 15) m_ph = 3; end
      3: begin m_g = dn(m_g); if (m_g == 0)  m_ph = 4; end
      4: begin m_r = up(m_r); if (m_r == 15) m_ph = 5; end
      default: begin m_b = dn(m_b); if (m_b == 0) m_ph = 0; end
    endcase
  endfunction

  // driver + scoreboard: drive at negedge, compare #1 after the next posedge
  task automatic apply(input vec_t v, input int idx);
    logic [27:0] act, exp;
    @(negedge clk);
    rst  = v.rst;
    en   = v.en;
    ps8  = (v.sel == 0) && v.ps;
    ps4a = (v.sel == 1) && v.ps;
    ps4b = (v.sel == 2) && v.ps;
    exp_q.push_back(v.exp);
    @(posedge clk);
    #1;
    case (v.sel)
      0:       act = {r8, g8, b8, ph8, upd8};
      1:       act = {4'd0, r4a, 4'd0, g4a, 4'd0, b4a, ph4a, upd4a};
      default: act = {4'd0, r4b, 4'd0, g4b, 4'd0, b4b, ph4b, upd4b};
    endcase
    exp = exp_q.pop_front();
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL vec%0d dut%0d: got r=%0d g=%0d b=%0d ph=%0d upd=%0d, expected r=%0d g=%0d b=%0d ph=%0d upd=%0d",
                  idx, v.sel, act[27:20], act[19:12], act[11:4], act[3:1], act[0],
                  exp[27:20], exp[19:12], exp[11:4], exp[3:1], exp[0]);
  endtask

  initial begin
    // reset held two cycles, then idle checks of the W=4 instances
    add(0, 1, 1, 0, 255, 0, 0, 0, 0);
    add(0, 1, 1, 0, 255, 0, 0, 0, 0);
    add(1, 0, 1, 0, 15, 0, 0, 0, 0);
    add(2, 0, 1, 0, 15, 0, 0, 0, 0);

    // pulse counting: the 4th pulse steps green
    for (int i = 0; i < 3; i++) add(0, 0, 1, 1, 255, 0, 0, 0, 0);
    add(0, 0, 1, 0, 255, 0, 0, 0, 0);
    add(0, 0, 1, 1, 255, 1, 0, 0, 1);
    add(0, 0, 1, 0, 255, 1, 0, 0, 0);

    // enable gating: 2 counted, 10 ignored, then 2 more complete the step
    for (int i = 0; i < 2; i++)  add(0, 0, 1, 1, 255, 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) add(0, 0, 0, 1, 255, 1, 0, 0, 0);
    add(0, 0, 1, 0, 255, 1, 0, 0, 0);
    add(0, 0, 1, 1, 255, 1, 0, 0, 0);
    add(0, 0, 1, 1, 255, 2, 0, 0, 1);
    add(0, 0, 1, 1, 255, 2, 0, 0, 0);

    // saturation and phase advance with STEP=4, one period per step
    add(1, 0, 1, 1, 15, 4, 0, 0, 1);
    add(1, 0, 1, 1, 15, 8, 0, 0, 1);
    add(1, 0, 1, 1, 15, 12, 0, 0, 1);
    add(1, 0, 1, 1, 15, 15, 0, 1, 1);
    add(1, 0, 1, 0, 15, 15, 0, 1, 0);
    add(1, 0, 1, 1, 11, 15, 0, 1, 1);

    // full wheel with STEP=5: 18 back-to-back steps return to pure red
    for (int i = 0; i < 18; i++) begin
      model_step();
      add(2, 0, 1, 1, m_r, m_g, m_b, m_ph, 1);
    end
    add(2, 0, 1, 0, 15, 0, 0, 0, 0);

    // walk into phase 3, then reset on a stepping pulse
    for (int i = 0; i < 10; i++) begin
      model_step();
      add(2, 0, 1, 1, m_r, m_g, m_b, m_ph, 1);
    end
    add(2, 1, 1, 1, 15, 0, 0, 0, 0);
    add(2, 0, 1, 0, 15, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
